// File: rtl/two_bit_adder_pkg.sv
// Shared width constant for the two-bit adder/subtractor slice.
package two_bit_adder_pkg;
    localparam int unsigned ADD_W = 2;
endpackage

// File: rtl/two_bit_adder_full_adder.sv
// Single-bit full adder; rippled by two_bit_adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/two_bit_adder.sv
// 2-bit ripple-carry adder/subtractor with one output register stage.
module two_bit_adder
    import two_bit_adder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       Cin0,
    input  logic       subtract,
    output logic       sum0,
    output logic       sum1,
    output logic       C1
);
    logic [ADD_W-1:0] b_eff;
    logic [ADD_W:0]   carry;
    logic [ADD_W-1:0] s;
    logic [ADD_W:0]   res_d, res_q;

    // Subtract is a + ~b + ~Cin0, so carry-out high means no borrow.
    assign b_eff    = b ^ {ADD_W{subtract}};
    assign carry[0] = Cin0 ^ subtract;

    for (genvar i = 0; i < ADD_W; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b_eff[i]),
            .cin  (carry[i]),
            .s    (s[i]),
            .cout (carry[i+1])
        );
    end

    assign res_d = {carry[ADD_W], s};

    always_ff @(posedge clk) begin
        if (reset) res_q <= '0;
        else       res_q <= res_d;
    end

    assign sum0 = res_q[0];
    assign sum1 = res_q[1];
    assign C1   = res_q[2];
endmodule

// File: tb/tb_two_bit_adder.sv
// Directed + exhaustive + random checks of two_bit_adder against an arithmetic model.
module tb_two_bit_adder;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] a, b;
    logic       Cin0, subtract;
    logic       sum0, sum1, C1;
    int         total = 0;
    int         bad   = 0;

    two_bit_adder dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .Cin0     (Cin0),
        .subtract (subtract),
        .sum0     (sum0),
        .sum1     (sum1),
        .C1       (C1)
    );

    always #5 clk = ~clk;

    // {C1, sum1, sum0} from plain integer arithmetic.
    function automatic logic [2:0] model(input int av, input int bv, input int cv, input int sv);
        int d;
        if (sv == 0) begin
            d = av + bv + cv;
            return d[2:0];
        end
        d = av - bv - cv;
        return {(d >= 0) ? 1'b1 : 1'b0, 2'((d + 4) % 4)};
    endfunction

    task automatic step(input logic [1:0] ai, input logic [1:0] bi, input logic ci,
                        input logic si, input logic ri);
        @(negedge clk);
        a = ai; b = bi; Cin0 = ci; subtract = si; reset = ri;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [2:0] exp);
        logic [2:0] obs;
        obs = {C1, sum1, sum0};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] ra, rb;
        logic       rc, rs;
        reset = 1'b1; a = 2'b11; b = 2'b10; Cin0 = 1'b1; subtract = 1'b0;

        step(2'b11, 2'b11, 1'b1, 1'b0, 1'b1); check("reset_e1", 3'b000);
        step(2'b10, 2'b01, 1'b0, 1'b1, 1'b1); check("reset_e2", 3'b000);

        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0); check("add_0_0", 3'b000);
        step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0); check("add_1_0", 3'b001);
        step(2'b00, 2'b01, 1'b0, 1'b0, 1'b0); check("add_0_1", 3'b001);
        step(2'b10, 2'b11, 1'b0, 1'b0, 1'b0); check("add_2_3", 3'b101);
        step(2'b11, 2'b11, 1'b0, 1'b0, 1'b0); check("add_3_3", 3'b110);
        step(2'b11, 2'b01, 1'b0, 1'b0, 1'b0); check("add_3_1", 3'b100);
        step(2'b11, 2'b11, 1'b1, 1'b0, 1'b0); check("add_3_3_c", 3'b111);
        step(2'b10, 2'b01, 1'b0, 1'b1, 1'b0); check("sub_2_1", 3'b101);
        step(2'b10, 2'b01, 1'b1, 1'b1, 1'b0); check("sub_2_1_b", 3'b100);
        step(2'b01, 2'b10, 1'b0, 1'b1, 1'b0); check("sub_1_2", 3'b011);

        // Outputs must hold while inputs move between edges.
        @(negedge clk);
        a = 2'b11; b = 2'b11; Cin0 = 1'b1; subtract = 1'b0;
        #2 check("hold", 3'b011);

        for (int i = 0; i < 64; i++) begin
            logic [5:0] v;
            v = 6'(i);
            if (i == 30) begin
                step(v[5:4], v[3:2], v[1], v[0], 1'b1);
                check("exh_reset", 3'b000);
            end
            step(v[5:4], v[3:2], v[1], v[0], 1'b0);
            check($sformatf("exh_%0d", i),
                  model(int'(v[5:4]), int'(v[3:2]), int'(v[1]), int'(v[0])));
        end

        for (int i = 0; i < 40; i++) begin
            ra = 2'($urandom_range(0, 3));
            rb = 2'($urandom_range(0, 3));
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            step(ra, rb, rc, rs, 1'b0);
            check($sformatf("rnd_%0d", i), model(int'(ra), int'(rb), int'(rc), int'(rs)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
